// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with optional two-entry skid buffer
// Control field is zeroed for any invalid entry so a bubble can never commit state.
module pipe_stage_reg #(
  parameter int DATA_W = 69,
  parameter int CTRL_W = 2,
  parameter int SKID   = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        count_o
);

  logic              m_valid_q, m_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q,  m_ctrl_d;
  logic [DATA_W-1:0] m_data_q,  m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] s_ctrl_q,  s_ctrl_d;
  logic [DATA_W-1:0] s_data_q,  s_data_d;

  logic in_ready;
  logic accept;
  logic drain;

  // With the skid buffer, ready depends only on state, breaking the out_ready_i -> in_ready_o path.
  assign in_ready = !rst_i && ((SKID != 0) ? !s_valid_q : (!m_valid_q || out_ready_i));
  assign accept   = in_valid_i && in_ready;
  assign drain    = m_valid_q && out_ready_i;

  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_ctrl_d  = s_ctrl_q;
    s_data_d  = s_data_q;

    if ((SKID != 0) && drain && s_valid_q) begin
      m_valid_d = 1'b1;
      m_ctrl_d  = s_ctrl_q;
      m_data_d  = s_data_q;
      s_valid_d = 1'b0;
      s_ctrl_d  = '0;
    end else if (accept && (!m_valid_q || drain)) begin
      m_valid_d = 1'b1;
      m_ctrl_d  = in_ctrl_i;
      m_data_d  = in_data_i;
    end else if (accept && (SKID != 0)) begin
      s_valid_d = 1'b1;
      s_ctrl_d  = in_ctrl_i;
      s_data_d  = in_data_i;
    end else if (drain) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
    end

    // A squashed accept completes upstream but leaves no trace, not even in the payload.
    if (flush_i) begin
      m_valid_d = 1'b0;
      m_ctrl_d  = '0;
      m_data_d  = m_data_q;
      s_valid_d = 1'b0;
      s_ctrl_d  = '0;
      s_data_d  = s_data_q;
    end

    if (SKID == 0) begin
      s_valid_d = 1'b0;
      s_ctrl_d  = '0;
      s_data_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      m_valid_q <= 1'b0;
      m_ctrl_q  <= '0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_ctrl_q  <= '0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_ctrl_q  <= m_ctrl_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_ctrl_q  <= s_ctrl_d;
      s_data_q  <= s_data_d;
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = m_valid_q;
  assign out_ctrl_o  = m_ctrl_q & {CTRL_W{m_valid_q}};
  assign out_data_o  = m_data_q;
  assign count_o     = {1'b0, m_valid_q} + {1'b0, s_valid_q};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed vector bench for pipe_stage_reg in skid and non-skid modes
module tb_pipe_stage_reg;
  localparam int DW = 69;
  localparam int CW = 2;

  typedef struct {
    logic          rst, flush, iv;
    logic [CW-1:0] ictrl;
    logic [DW-1:0] idata;
    logic          ordy;
    logic          ov;
    logic [CW-1:0] oc;
    logic [DW-1:0] od;
    logic [1:0]    cnt;
    logic          ir;
    logic [4:0]    chk;  // {ov, oc, od, cnt, ir}
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst1, flush1, iv1, ordy1, ir1, ov1;
  logic [CW-1:0] ictrl1, oc1;
  logic [DW-1:0] idata1, od1;
  logic [1:0]    cnt1;
  logic          rst0, flush0, iv0, ordy0, ir0, ov0;
  logic [CW-1:0] ictrl0, oc0;
  logic [DW-1:0] idata0, od0;
  logic [1:0]    cnt0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) dut1 (
    .clk_i(clk), .rst_i(rst1), .flush_i(flush1),
    .in_valid_i(iv1), .in_ready_o(ir1), .in_ctrl_i(ictrl1), .in_data_i(idata1),
    .out_valid_o(ov1), .out_ready_i(ordy1), .out_ctrl_o(oc1), .out_data_o(od1),
    .count_o(cnt1)
  );

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0)) dut0 (
    .clk_i(clk), .rst_i(rst0), .flush_i(flush0),
    .in_valid_i(iv0), .in_ready_o(ir0), .in_ctrl_i(ictrl0), .in_data_i(idata0),
    .out_valid_o(ov0), .out_ready_i(ordy0), .out_ctrl_o(oc0), .out_data_o(od0),
    .count_o(cnt0)
  );

  int n_chk  = 0;
  int n_fail = 0;

  vec_t t1[$];
  vec_t t0[$];

  function automatic vec_t v(input int rst, flush, iv, ictrl, idata, ordy,
                             ov, oc, od, cnt, ir, chk);
    vec_t r;
    r.rst = rst[0]; r.flush = flush[0]; r.iv = iv[0];
    r.ictrl = ictrl[CW-1:0]; r.idata = DW'(idata); r.ordy = ordy[0];
    r.ov = ov[0]; r.oc = oc[CW-1:0]; r.od = DW'(od);
    r.cnt = cnt[1:0]; r.ir = ir[0]; r.chk = chk[4:0];
    return r;
  endfunction

  task automatic check(input string nm, input int row, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
    end
  endtask

  task automatic check_row(input string tag, input int i, input vec_t e, input logic a_ov,
                           input logic [CW-1:0] a_oc, input logic [DW-1:0] a_od,
                           input logic [1:0] a_cnt, input logic a_ir);
    if (e.chk[4]) check({tag, "_out_valid"}, i, DW'(a_ov), DW'(e.ov));
    if (e.chk[3]) check({tag, "_out_ctrl"},  i, DW'(a_oc), DW'(e.oc));
    if (e.chk[2]) check({tag, "_out_data"},  i, a_od, e.od);
    if (e.chk[1]) check({tag, "_count"},     i, DW'(a_cnt), DW'(e.cnt));
    if (e.chk[0]) check({tag, "_in_ready"},  i, DW'(a_ir), DW'(e.ir));
  endtask

  initial begin
    logic [DW-1:0] exp_q[$];
    int            nxt;
    int            qs;

    rst1 = 1; flush1 = 0; iv1 = 0; ictrl1 = 0; idata1 = 0; ordy1 = 0;
    rst0 = 1; flush0 = 0; iv0 = 0; ictrl0 = 0; idata0 = 0; ordy0 = 0;

    // Rows: rst flush iv ictrl idata ordy | expected ov oc od cnt ir, check mask.
    t1.push_back(v(1,0,0,0,0,1, 0,0,0,0,0, 1));
    t1.push_back(v(1,0,0,0,0,1, 0,0,0,0,0, 31));
    t1.push_back(v(0,0,1,3,1,1, 0,0,0,0,1, 31));
    for (int d = 2; d <= 8; d++) t1.push_back(v(0,0,1,3,d,1, 1,3,d-1,1,1, 31));
    t1.push_back(v(0,0,0,0,0,1, 1,3,8,1,1, 31));
    t1.push_back(v(0,0,0,3,0,1, 0,0,8,0,1, 31));
    t1.push_back(v(0,0,1,3,1,1, 0,0,8,0,1, 31));
    t1.push_back(v(0,0,1,3,2,1, 1,3,1,1,1, 31));
    t1.push_back(v(0,0,1,2,3,0, 1,3,2,1,1, 31));
    t1.push_back(v(0,0,1,3,4,0, 1,3,2,2,0, 31));
    t1.push_back(v(0,0,1,3,4,0, 1,3,2,2,0, 31));
    t1.push_back(v(0,0,1,3,4,1, 1,3,2,2,0, 31));
    t1.push_back(v(0,0,1,3,4,1, 1,2,3,1,1, 31));
    t1.push_back(v(0,0,1,3,5,1, 1,3,4,1,1, 31));
    t1.push_back(v(0,0,1,3,6,1, 1,3,5,1,1, 31));
    t1.push_back(v(0,0,0,0,0,0, 1,3,6,1,1, 31));
    t1.push_back(v(0,0,1,3,7,0, 1,3,6,1,1, 31));
    t1.push_back(v(0,1,1,3,9,0, 1,3,6,2,0, 31));
    t1.push_back(v(0,0,0,0,0,1, 0,0,6,0,1, 31));
    t1.push_back(v(0,0,1,3,10,0, 0,0,6,0,1, 31));
    t1.push_back(v(0,1,1,3,9,0, 1,3,10,1,1, 31));
    t1.push_back(v(0,0,0,0,0,1, 0,0,10,0,1, 31));
    t1.push_back(v(0,0,1,3,11,0, 0,0,10,0,1, 31));
    t1.push_back(v(0,0,1,3,12,0, 1,3,11,1,1, 31));
    t1.push_back(v(1,0,1,3,13,0, 1,3,11,2,0, 31));
    t1.push_back(v(0,0,0,0,0,0, 0,0,0,0,1, 31));

    t0.push_back(v(1,0,0,0,0,1, 0,0,0,0,0, 1));
    t0.push_back(v(1,0,0,0,0,1, 0,0,0,0,0, 31));
    t0.push_back(v(0,0,1,3,1,1, 0,0,0,0,1, 31));
    t0.push_back(v(0,0,1,1,2,1, 1,3,1,1,1, 31));
    t0.push_back(v(0,0,1,3,3,0, 1,1,2,1,0, 31));
    t0.push_back(v(0,0,1,3,3,1, 1,1,2,1,1, 31));
    t0.push_back(v(0,0,1,3,4,1, 1,3,3,1,1, 31));
    t0.push_back(v(0,0,0,0,0,0, 1,3,4,1,0, 31));
    t0.push_back(v(0,0,0,0,0,1, 1,3,4,1,1, 31));
    t0.push_back(v(0,0,0,3,0,0, 0,0,4,0,1, 31));
    t0.push_back(v(0,1,1,3,5,0, 0,0,4,0,1, 31));
    t0.push_back(v(0,0,0,0,0,0, 0,0,4,0,1, 31));

    for (int i = 0; i < t1.size(); i++) begin
      @(negedge clk);
      rst1 = t1[i].rst; flush1 = t1[i].flush; iv1 = t1[i].iv;
      ictrl1 = t1[i].ictrl; idata1 = t1[i].idata; ordy1 = t1[i].ordy;
      #2;
      check_row("skid", i, t1[i], ov1, oc1, od1, cnt1, ir1);
    end

    for (int i = 0; i < t0.size(); i++) begin
      @(negedge clk);
      rst0 = t0[i].rst; flush0 = t0[i].flush; iv0 = t0[i].iv;
      ictrl0 = t0[i].ictrl; idata0 = t0[i].idata; ordy0 = t0[i].ordy;
      #2;
      check_row("noskid", i, t0[i], ov0, oc0, od0, cnt0, ir0);
    end

    // Random-backpressure stream on the skid stage against a FIFO reference.
    nxt = 100;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      rst1 = 0; flush1 = 0; ictrl1 = 2'b11; idata1 = DW'(nxt);
      iv1 = 1'($urandom_range(0, 1)); ordy1 = 1'($urandom_range(0, 1));
      #2;
      qs = exp_q.size();
      check("rand_count", c, DW'(cnt1), DW'(qs));
      check("rand_in_ready", c, DW'(ir1), DW'(qs < 2));
      if (ov1) check("rand_out_ctrl", c, DW'(oc1), DW'(2'b11));
      if (ov1 && ordy1) begin
        if (qs == 0) check("rand_spurious", c, DW'(ov1), DW'(0));
        else check("rand_order", c, od1, exp_q.pop_front());
      end
      if (iv1 && ir1) begin
        exp_q.push_back(DW'(nxt));
        nxt++;
      end
    end
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      iv1 = 0; ordy1 = 1;
      #2;
      if (ov1) check("drain_order", c, od1, exp_q.pop_front());
      else check("drain_valid", c, DW'(ov1), DW'(1));
    end
    check("drain_left", 0, DW'(exp_q.size()), DW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
